// File: rtl/cp_trim_calibrator.sv
// SAR calibration controller for the PLL charge pump: measures the up-source current,
// then binary-searches the down-current trim code until the down current matches it.
module cp_trim_calibrator #(
   parameter int unsigned TRIM_W        = 12,
   parameter int unsigned INT_CYCLES    = 16,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned RESET_CODE    = 1342
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic        pfd_up,
   input  logic        pfd_down,
   input  logic [23:0] cp_current_in,
   output logic        cp_up,
   output logic        cp_down,
   output logic [25:0] down_current_code,
   output logic        busy,
   output logic        done,
   output logic        cal_valid
);

   localparam int unsigned       IDX_W       = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
   localparam logic [8:0]        SETTLE_LAST = 9'(SETTLE_CYCLES - 1);
   localparam logic [8:0]        INT_LAST    = 9'(INT_CYCLES - 1);
   localparam logic [IDX_W-1:0]  IDX_TOP     = IDX_W'(TRIM_W - 1);
   localparam logic [TRIM_W-1:0] CODE_RST    = TRIM_W'(RESET_CODE);

   typedef enum logic [2:0] {
      IDLE,
      UP_SETTLE,
      UP_INT,
      DN_SETTLE,
      DN_INT,
      COMPARE,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [8:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [TRIM_W-1:0] code_q, code_d;
   logic [TRIM_W-1:0] saved_q, saved_d;
   logic [31:0]       acc_up_q, acc_up_d;
   logic [31:0]       acc_dn_q, acc_dn_d;
   logic              cp_up_q, cp_up_d;
   logic              cp_dn_q, cp_dn_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              valid_q, valid_d;
   logic [TRIM_W-1:0] idx_bit;
   logic [TRIM_W-1:0] kept;
   logic [31:0]       cur_ext;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      code_d   = code_q;
      saved_d  = saved_q;
      acc_up_d = acc_up_q;
      acc_dn_d = acc_dn_q;
      valid_d  = valid_q;
      idx_bit  = TRIM_W'(1) << idx_q;
      // A tie between the two measurements keeps the trial bit.
      kept     = (acc_dn_q > acc_up_q) ? (code_q & ~idx_bit) : code_q;
      cur_ext  = {8'd0, cp_current_in};

      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d = UP_SETTLE;
               saved_d = code_q;
               idx_d   = IDX_TOP;
               cnt_d   = '0;
            end
         end
         UP_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = UP_INT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 9'd1;
            end
         end
         UP_INT: begin
            acc_up_d = acc_up_q + cur_ext;
            if (cnt_q == INT_LAST) begin
               state_d = DN_SETTLE;
               cnt_d   = '0;
               code_d  = idx_bit;
            end else begin
               cnt_d = cnt_q + 9'd1;
            end
         end
         DN_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = DN_INT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 9'd1;
            end
         end
         DN_INT: begin
            acc_dn_d = acc_dn_q + cur_ext;
            if (cnt_q == INT_LAST) begin
               state_d = COMPARE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 9'd1;
            end
         end
         COMPARE: begin
            acc_dn_d = '0;
            if (idx_q == '0) begin
               state_d = DONE;
               code_d  = kept;
               valid_d = 1'b1;
            end else begin
               state_d = DN_SETTLE;
               idx_d   = idx_q - 1'b1;
               code_d  = kept | (idx_bit >> 1);
            end
         end
         DONE: begin
            acc_up_d = '0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (abort && (state_q != IDLE)) begin
         state_d  = IDLE;
         code_d   = saved_q;
         valid_d  = 1'b0;
         acc_up_d = '0;
         acc_dn_d = '0;
         cnt_d    = '0;
      end

      done_d = (state_d == DONE);
      busy_d = (state_d != IDLE);
      // Pass-through only resumes one cycle after leaving a calibration.
      if ((state_q == IDLE) && (state_d == IDLE)) begin
         cp_up_d = pfd_up;
         cp_dn_d = pfd_down;
      end else begin
         cp_up_d = (state_d == UP_SETTLE) || (state_d == UP_INT);
         cp_dn_d = (state_d == DN_SETTLE) || (state_d == DN_INT);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         code_q   <= CODE_RST;
         saved_q  <= CODE_RST;
         acc_up_q <= '0;
         acc_dn_q <= '0;
         cp_up_q  <= 1'b0;
         cp_dn_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         code_q   <= code_d;
         saved_q  <= saved_d;
         acc_up_q <= acc_up_d;
         acc_dn_q <= acc_dn_d;
         cp_up_q  <= cp_up_d;
         cp_dn_q  <= cp_dn_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         valid_q  <= valid_d;
      end
   end

   assign cp_up             = cp_up_q;
   assign cp_down           = cp_dn_q;
   assign down_current_code = 26'(code_q);
   assign busy              = busy_q;
   assign done              = done_q;
   assign cal_valid         = valid_q;

endmodule
